// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared types for the CPU/video memory bus arbiter.
//   state_e  - three-phase access sequencer state (StIdle/StAccess/StData)
//   owner_e  - which requester holds the current access (OwnCpu=0, OwnVid=1)
//   STARVE_W - width of the CPU starvation counter
package mem_bus_arbiter_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StData   = 2'd2
  } state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnVid = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one byte-wide synchronous RAM (registered read, 1-cycle latency)
// between the CPU (read/write) and the video fetcher (read-only). Each access is a fixed
// IDLE -> ACCESS -> DATA sequence. Video wins contention unless the CPU has been passed over
// CPU_STARVE_MAX times in a row.
//
// Ports:
//   clock_25, reset              - clock, synchronous active-high reset
//   cpu_req/addr/wdata/we        - CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack           - CPU read data (valid with ack), one-cycle completion pulse
//   vid_req/addr                 - video read request, held until vid_ack
//   vid_rdata, vid_ack           - video read data (valid with ack), one-cycle completion pulse
//   mem_addr/wdata/we, mem_rdata - RAM interface
//   wprot_hit                    - (MEM_BUS_ARBITER_WPROT_EN only) pulses with cpu_ack when a
//                                  CPU write at or above ROM_BASE was suppressed
//
// Optional feature macro: MEM_BUS_ARBITER_WPROT_EN (write protection of ROM_BASE and up).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned CPU_STARVE_MAX = 4
`ifdef MEM_BUS_ARBITER_WPROT_EN
  ,
  parameter logic [15:0] ROM_BASE = 16'hC000
`endif
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
`ifdef MEM_BUS_ARBITER_WPROT_EN
  ,
  output logic        wprot_hit
`endif
);

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(CPU_STARVE_MAX);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_ack_q, vid_ack_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d;
  logic [7:0]          vid_rdata_q, vid_rdata_d;
  logic                grant_cpu, grant_vid;
  logic                wr_block;

`ifdef MEM_BUS_ARBITER_WPROT_EN
  assign wr_block = cpu_we && (cpu_addr >= ROM_BASE);
`else
  assign wr_block = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    grant_cpu   = 1'b0;
    grant_vid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_cpu = cpu_req && (!vid_req || (starve_q == StarveMax));
        grant_vid = vid_req && !grant_cpu;
        // Any idle cycle without a CPU request forgives the CPU's backlog.
        if (!cpu_req || grant_cpu) begin
          starve_d = '0;
        end else if (grant_vid && (starve_q != StarveMax)) begin
          starve_d = starve_q + 1'b1;
        end
        if (grant_cpu) begin
          owner_d     = OwnCpu;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_we_d    = cpu_we && !wr_block;
          state_d     = StAccess;
        end else if (grant_vid) begin
          owner_d    = OwnVid;
          mem_addr_d = vid_addr;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        // Ack is registered here so it is high exactly during DATA.
        cpu_ack_d = (owner_q == OwnCpu);
        vid_ack_d = (owner_q == OwnVid);
        state_d   = StData;
      end
      StData: begin
        if (owner_q == OwnCpu) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          vid_rdata_d = mem_rdata;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

`ifdef MEM_BUS_ARBITER_WPROT_EN
  logic wprot_pend_q, wprot_pend_d;
  logic wprot_hit_q, wprot_hit_d;

  always_comb begin
    wprot_pend_d = wprot_pend_q;
    if (grant_cpu) begin
      wprot_pend_d = wr_block;
    end
    wprot_hit_d = (state_q == StAccess) && (owner_q == OwnCpu) && wprot_pend_q;
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      wprot_pend_q <= 1'b0;
      wprot_hit_q  <= 1'b0;
    end else begin
      wprot_pend_q <= wprot_pend_d;
      wprot_hit_q  <= wprot_hit_d;
    end
  end

  assign wprot_hit = wprot_hit_q;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  // RAM data only arrives during DATA, so the capture register is bypassed in that cycle to
  // make rdata valid alongside ack; afterwards the register holds it.
  assign cpu_rdata = cpu_rdata_d;
  assign vid_rdata = vid_rdata_d;

endmodule
